// File: rtl/spinn_aer_dump_ctrl_pkg.sv
// Shared definitions for the AER event-dump controller: FSM encodings, default
// parameter values and the counter-width helper.
package spinn_aer_dump_ctrl_pkg;

    localparam logic [0:0] DUMP_PASS_ST = 1'b0;
    localparam logic [0:0] DUMP_DUMP_ST = 1'b1;

    localparam int PKT_BITS_DEF    = 72;
    localparam int NUM_CH_DEF      = 4;
    localparam int DUMP_CNT_DEF    = 128;
    localparam int RECOVER_CNT_DEF = 16;
    localparam int STAT_BITS_DEF   = 32;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int ctr_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/spinn_aer_dump_ctrl_ch.sv
// One dump-controller channel: output register, busy/ready counters, PASS/DUMP FSM.
// Dropped-packet statistics are built only when SPIO_DUMP_STATS_EN is defined.
module spinn_aer_dump_ctrl_ch
    import spinn_aer_dump_ctrl_pkg::*;
#(
    parameter int PKT_BITS    = PKT_BITS_DEF,
    parameter int DUMP_CNT    = DUMP_CNT_DEF,
    parameter int RECOVER_CNT = RECOVER_CNT_DEF,
    parameter int STAT_BITS   = STAT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 stat_clr,
    input  logic [PKT_BITS-1:0]  in_data,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [PKT_BITS-1:0]  out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 dump_mode,
    output logic [STAT_BITS-1:0] drop_cnt
);

    localparam int            CW        = ctr_width(DUMP_CNT, RECOVER_CNT);
    localparam logic [CW-1:0] BUSY_LAST = CW'(DUMP_CNT - 1);
    localparam logic [CW-1:0] RDY_LAST  = CW'(RECOVER_CNT - 1);

    logic [0:0]    state;
    logic [CW-1:0] busy_ctr;
    logic [CW-1:0] rdy_ctr;
    logic          accept, drop, load, busy, dump_enter, dump_exit;

    assign dump_mode  = (state == DUMP_DUMP_ST);
    assign in_rdy     = dump_mode | ~go | ~out_vld | out_rdy;
    assign accept     = in_vld & in_rdy;
    assign drop       = accept & (dump_mode | ~go);
    assign load       = accept & ~drop;
    assign busy       = out_vld & ~out_rdy;
    // A load can never coincide with entry: entry needs busy, load needs !busy.
    assign dump_enter = ~dump_mode & busy & (busy_ctr == BUSY_LAST);
    assign dump_exit  = dump_mode & out_rdy & (rdy_ctr == RDY_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DUMP_PASS_ST;
            busy_ctr <= '0;
            rdy_ctr  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (dump_enter)   out_vld <= 1'b0;
            else if (load)    out_vld <= 1'b1;
            else if (out_rdy) out_vld <= 1'b0;

            if (load) out_data <= in_data;

            if (!busy)                       busy_ctr <= '0;
            else if (busy_ctr != BUSY_LAST) busy_ctr <= busy_ctr + CW'(1);

            if (dump_mode && out_rdy && !dump_exit) rdy_ctr <= rdy_ctr + CW'(1);
            else                                    rdy_ctr <= '0;

            if (dump_enter)     state <= DUMP_DUMP_ST;
            else if (dump_exit) state <= DUMP_PASS_ST;
        end
    end

`ifdef SPIO_DUMP_STATS_EN
    logic [STAT_BITS-1:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                stat_q <= '0;
        else if (stat_clr)                         stat_q <= '0;
        else if ((drop || dump_enter) && stat_q != '1) stat_q <= stat_q + STAT_BITS'(1);
    end

    assign drop_cnt = stat_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign drop_cnt        = '0;
`endif

endmodule

// File: rtl/spinn_aer_dump_ctrl.sv
// Multi-channel AER event-dump controller: NUM_CH independent channels on sliced
// buses. Define SPIO_DUMP_STATS_EN to build the per-channel drop counters.
module spinn_aer_dump_ctrl
    import spinn_aer_dump_ctrl_pkg::*;
#(
    parameter int PKT_BITS    = PKT_BITS_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DUMP_CNT    = DUMP_CNT_DEF,
    parameter int RECOVER_CNT = RECOVER_CNT_DEF,
    parameter int STAT_BITS   = STAT_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           go,
    output logic [NUM_CH-1:0]           dump_mode,
    input  logic                        stat_clr,
    output logic [NUM_CH*STAT_BITS-1:0] drop_cnt,
    input  logic [NUM_CH*PKT_BITS-1:0]  in_data,
    input  logic [NUM_CH-1:0]           in_vld,
    output logic [NUM_CH-1:0]           in_rdy,
    output logic [NUM_CH*PKT_BITS-1:0]  out_data,
    output logic [NUM_CH-1:0]           out_vld,
    input  logic [NUM_CH-1:0]           out_rdy
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        spinn_aer_dump_ctrl_ch #(
            .PKT_BITS    (PKT_BITS),
            .DUMP_CNT    (DUMP_CNT),
            .RECOVER_CNT (RECOVER_CNT),
            .STAT_BITS   (STAT_BITS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .go        (go[c]),
            .stat_clr  (stat_clr),
            .in_data   (in_data[c*PKT_BITS +: PKT_BITS]),
            .in_vld    (in_vld[c]),
            .in_rdy    (in_rdy[c]),
            .out_data  (out_data[c*PKT_BITS +: PKT_BITS]),
            .out_vld   (out_vld[c]),
            .out_rdy   (out_rdy[c]),
            .dump_mode (dump_mode[c]),
            .drop_cnt  (drop_cnt[c*STAT_BITS +: STAT_BITS])
        );
    end

endmodule

// File: tb/tb_spinn_aer_dump_ctrl.sv
// Self-checking bench for spinn_aer_dump_ctrl: vector table on ch1, scoreboard on
// ch0 deliveries, hand-written dump/recovery/reset sequences, DUMP_CNT=1 instance.
module tb_spinn_aer_dump_ctrl;

`ifdef SPIO_DUMP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk, rst_n, stat_clr;
    logic [1:0]  go, in_vld, in_rdy, out_vld, out_rdy, dump_mode;
    logic [31:0] in_data, out_data;
    logic [15:0] drop_cnt;

    logic [0:0]  go1, iv1, ir1, ov1, ordy1, dm1;
    logic [15:0] id1, od1;
    logic [7:0]  dc1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb_q[$];

    spinn_aer_dump_ctrl #(
        .PKT_BITS(16), .NUM_CH(2), .DUMP_CNT(8), .RECOVER_CNT(4), .STAT_BITS(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go), .dump_mode(dump_mode), .stat_clr(stat_clr),
        .drop_cnt(drop_cnt), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    spinn_aer_dump_ctrl #(
        .PKT_BITS(16), .NUM_CH(1), .DUMP_CNT(1), .RECOVER_CNT(1), .STAT_BITS(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .go(go1), .dump_mode(dm1), .stat_clr(stat_clr),
        .drop_cnt(dc1), .in_data(id1), .in_vld(iv1), .in_rdy(ir1),
        .out_data(od1), .out_vld(ov1), .out_rdy(ordy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xd(input logic [7:0] v);
        return STATS_EN ? v : 8'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ch0 handshake must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n && out_vld[0] && out_rdy[0]) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0h expected nothing", out_data[15:0]);
            end else begin
                check("sb_data", {16'd0, out_data[15:0]}, {16'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        go, vld, rdy;
        logic [15:0] data;
        logic        exp_in_rdy, exp_vld;
        logic [15:0] exp_data;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 1, 0, 16'hA001, 1, 1, 16'hA001, 0};
        vt[1] = '{1, 1, 0, 16'hA002, 0, 1, 16'hA001, 0};
        vt[2] = '{1, 1, 1, 16'hA003, 1, 1, 16'hA003, 0};
        vt[3] = '{0, 1, 0, 16'hA004, 1, 1, 16'hA003, 1};
        vt[4] = '{0, 0, 1, 16'hA005, 1, 0, 16'hA003, 1};
        vt[5] = '{1, 0, 0, 16'hA006, 1, 0, 16'hA003, 1};
        vt[6] = '{1, 1, 1, 16'hA007, 1, 1, 16'hA007, 1};
        vt[7] = '{1, 0, 1, 16'hA008, 1, 0, 16'hA007, 1};

        rst_n = 0; stat_clr = 0; go = 2'b11; in_vld = 0; out_rdy = 0; in_data = 0;
        go1 = 1; iv1 = 0; ordy1 = 0; id1 = 0;
        #12;
        check("rst_out_vld", {30'd0, out_vld}, 0);
        check("rst_in_rdy", {30'd0, in_rdy}, 32'h3);
        check("rst_dump_mode", {30'd0, dump_mode}, 0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk) rst_n = 1;
        cyc();

        // Vector table on ch1.
        for (int i = 0; i < 8; i++) begin
            go[1] = vt[i].go; in_vld[1] = vt[i].vld; out_rdy[1] = vt[i].rdy;
            in_data[31:16] = vt[i].data;
            #3 check($sformatf("vec%0d_in_rdy", i), {31'd0, in_rdy[1]}, {31'd0, vt[i].exp_in_rdy});
            cyc();
            check($sformatf("vec%0d_out_vld", i), {31'd0, out_vld[1]}, {31'd0, vt[i].exp_vld});
            check($sformatf("vec%0d_out_data", i), {16'd0, out_data[31:16]}, {16'd0, vt[i].exp_data});
            check($sformatf("vec%0d_drop", i), {24'd0, drop_cnt[15:8]}, {24'd0, xd(vt[i].exp_drop)});
        end
        go[1] = 1; in_vld[1] = 0; out_rdy[1] = 1;

        // Pass-through: 10 back-to-back packets on ch0.
        out_rdy[0] = 1;
        for (int i = 0; i < 10; i++) begin
            in_vld[0] = 1; in_data[15:0] = 16'h1000 + 16'(i);
            sb_q.push_back(16'h1000 + 16'(i));
            cyc();
            check("pt_latency", {15'd0, out_vld[0], out_data[15:0]}, {15'd0, 1'b1, 16'h1000 + 16'(i)});
        end
        in_vld[0] = 0;
        cyc(); cyc();
        check("pt_sb_empty", sb_q.size(), 0);
        check("pt_ch1_idle", {31'd0, out_vld[1]}, 0);
        check("pt_no_drop", {24'd0, drop_cnt[7:0]}, 0);

        // Dump entry after exactly 8 busy cycles.
        stat_clr = 1; cyc(); stat_clr = 0;
        out_rdy[0] = 0; in_vld[0] = 1; in_data[15:0] = 16'h2000;
        cyc();
        in_vld[0] = 0;
        repeat (7) cyc();
        check("de_before", {30'd0, dump_mode[0], out_vld[0]}, 32'h1);
        cyc();
        check("de_after", {30'd0, dump_mode[0], out_vld[0]}, 32'h2);
        check("de_drop", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd1)});
        check("de_in_rdy", {31'd0, in_rdy[0]}, 32'h1);

        // Discard 20 packets in DUMP, then recover.
        for (int i = 0; i < 20; i++) begin
            in_vld[0] = 1; in_data[15:0] = 16'h3000 + 16'(i);
            #3 check("dd_in_rdy", {31'd0, in_rdy[0]}, 32'h1);
            cyc();
        end
        in_vld[0] = 0;
        check("dd_drop", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd21)});
        check("dd_state", {30'd0, dump_mode[0], out_vld[0]}, 32'h2);
        begin
            logic [5:0] rdy_seq, dm_seq;
            rdy_seq = 6'b111101;
            dm_seq  = 6'b011111;
            for (int i = 0; i < 6; i++) begin
                out_rdy[0] = rdy_seq[i];
                if (i == 5) begin
                    in_vld[0] = 1; in_data[15:0] = 16'h3FFF;
                end
                cyc();
                check($sformatf("rc%0d_dump", i), {31'd0, dump_mode[0]}, {31'd0, dm_seq[i]});
            end
        end
        in_vld[0] = 0;
        check("rc_exit_drop", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd22)});
        check("rc_exit_vld", {31'd0, out_vld[0]}, 0);
        in_vld[0] = 1; in_data[15:0] = 16'h4000; sb_q.push_back(16'h4000);
        cyc();
        in_vld[0] = 0;
        check("rc_pass", {31'd0, out_vld[0]}, 32'h1);
        cyc();

        // go gating.
        stat_clr = 1; cyc(); stat_clr = 0;
        out_rdy[0] = 0; in_vld[0] = 1; in_data[15:0] = 16'h5000; sb_q.push_back(16'h5000);
        cyc();
        go[0] = 0; out_rdy[0] = 1;
        for (int i = 0; i < 5; i++) begin
            in_vld[0] = 1; in_data[15:0] = 16'h5100 + 16'(i);
            #3 check("gg_in_rdy", {31'd0, in_rdy[0]}, 32'h1);
            cyc();
        end
        in_vld[0] = 0;
        check("gg_drop", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd5)});
        check("gg_vld", {31'd0, out_vld[0]}, 0);
        go[0] = 1;
        for (int i = 0; i < 2; i++) begin
            in_vld[0] = 1; in_data[15:0] = 16'h5200 + 16'(i); sb_q.push_back(16'h5200 + 16'(i));
            cyc();
        end
        in_vld[0] = 0;
        cyc(); cyc();
        check("gg_sb_empty", sb_q.size(), 0);

        // Busy interruption: 7 busy, 1 ready, 7 busy.
        out_rdy[0] = 0; in_vld[0] = 1; in_data[15:0] = 16'h6000; sb_q.push_back(16'h6000);
        cyc();
        in_vld[0] = 0;
        repeat (7) cyc();
        check("bi_first", {31'd0, dump_mode[0]}, 0);
        out_rdy[0] = 1; in_vld[0] = 1; in_data[15:0] = 16'h6001; sb_q.push_back(16'h6001);
        cyc();
        out_rdy[0] = 0; in_vld[0] = 0;
        repeat (7) cyc();
        check("bi_second", {30'd0, dump_mode[0], out_vld[0]}, 32'h1);
        out_rdy[0] = 1;
        cyc();
        check("bi_end", {31'd0, dump_mode[0]}, 0);
        cyc();
        check("bi_sb_empty", sb_q.size(), 0);

        // stat_clr priority and saturation.
        go[0] = 0; in_vld[0] = 1;
        cyc();
        check("sc_pre", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd6)});
        stat_clr = 1;
        cyc();
        stat_clr = 0;
        check("sc_clr", {24'd0, drop_cnt[7:0]}, 0);
        repeat (300) cyc();
        check("sc_sat", {24'd0, drop_cnt[7:0]}, {24'd0, xd(8'd255)});
        in_vld[0] = 0; go[0] = 1;

        // Reset mid-stream discards the held packet.
        out_rdy[0] = 0; in_vld[0] = 1; in_data[15:0] = 16'h7000;
        cyc();
        in_vld[0] = 0;
        check("rm_held", {31'd0, out_vld[0]}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("rm_out_vld", {30'd0, out_vld}, 0);
        check("rm_out_data", out_data, 0);
        check("rm_dump", {30'd0, dump_mode}, 0);
        check("rm_drop", {16'd0, drop_cnt}, 0);
        check("rm_in_rdy", {30'd0, in_rdy}, 32'h3);
        @(negedge clk) rst_n = 1;
        out_rdy[0] = 1;
        cyc();
        check("rm_no_deliver", {31'd0, out_vld[0]}, 0);

        // DUMP_CNT=1 / RECOVER_CNT=1 instance.
        ordy1 = 0; iv1 = 1; id1 = 16'hBEEF;
        cyc();
        iv1 = 0;
        check("d1_load", {30'd0, dm1, ov1}, 32'h1);
        cyc();
        check("d1_enter", {30'd0, dm1, ov1}, 32'h2);
        check("d1_drop", {24'd0, dc1}, {24'd0, xd(8'd1)});
        ordy1 = 1;
        cyc();
        check("d1_exit", {31'd0, dm1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
